// File: rtl/pe_feeder_if.sv
// Stream and processing-element bus bundle for pe_feeder.
// master = the feeder side, slave = the stream source / PE side.
interface pe_feeder_if #(
    parameter int L_RAM_SIZE = 6
);
    logic [31:0]           s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic [31:0]           pe_ain;
    logic [31:0]           pe_din;
    logic [31:0]           pe_cin;
    logic [L_RAM_SIZE-1:0] pe_addr;
    logic                  pe_we;
    logic                  pe_valid;
    logic [31:0]           pe_dout;

    modport master (
        input  s_data, s_valid, pe_dout,
        output s_ready, pe_ain, pe_din, pe_cin, pe_addr, pe_we, pe_valid
    );

    modport slave (
        output s_data, s_valid, pe_dout,
        input  s_ready, pe_ain, pe_din, pe_cin, pe_addr, pe_we, pe_valid
    );
endinterface

// File: rtl/pe_feeder.sv
// pe_feeder: loads the B vector into PE RAM, then streams A one element at a
// time through the PE MAC, accumulating the Q24.8 dot product.
module pe_feeder #(
    parameter int L_RAM_SIZE  = 6,
    parameter int MAC_LATENCY = 4
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                start,
    input  logic [L_RAM_SIZE:0] len,
    pe_feeder_if.master         bus,
    output logic                busy,
    output logic                done,
    output logic [31:0]         result
);
    // state | meaning
    // IDLE  | waiting for start
    // LOAD  | writing B words into PE RAM
    // FETCH | waiting for the next A word
    // MAC   | PE operands held for MAC_LATENCY+1 cycles
    // DONE  | publish result; done pulses on exit
    typedef enum logic [2:0] {IDLE, LOAD, FETCH, MAC, DONE} state_t;

    localparam int CW = $clog2(MAC_LATENCY + 2);

    state_t                state, state_n;
    logic [L_RAM_SIZE:0]   len_q, len_n;
    logic [L_RAM_SIZE:0]   index, index_n, index_inc;
    logic [31:0]           acc, acc_n;
    logic [31:0]           a_reg, a_n;
    logic [31:0]           pe_din_q, din_n;
    logic [31:0]           result_n;
    logic [L_RAM_SIZE-1:0] pe_addr_q, addr_n;
    logic [CW-1:0]         mac_cnt, cnt_n;
    logic                  s_ready_q, sready_n;
    logic                  pe_we_q, we_n;
    logic                  pe_valid_q, valid_n;
    logic                  busy_n, done_n;
    logic                  accept;

    assign accept    = bus.s_valid && s_ready_q;
    assign index_inc = index + 1'b1;

    assign bus.s_ready  = s_ready_q;
    assign bus.pe_ain   = a_reg;
    assign bus.pe_din   = pe_din_q;
    assign bus.pe_cin   = acc;
    assign bus.pe_addr  = pe_addr_q;
    assign bus.pe_we    = pe_we_q;
    assign bus.pe_valid = pe_valid_q;

    always_comb begin
        state_n  = state;
        len_n    = len_q;
        index_n  = index;
        acc_n    = acc;
        a_n      = a_reg;
        cnt_n    = mac_cnt;
        din_n    = pe_din_q;
        addr_n   = pe_addr_q;
        result_n = result;
        we_n     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    len_n   = len;
                    index_n = '0;
                    acc_n   = '0;
                    state_n = (len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    we_n   = 1'b1;
                    addr_n = index[L_RAM_SIZE-1:0];
                    din_n  = bus.s_data;
                    if (index_inc == len_q) begin
                        index_n = '0;
                        state_n = FETCH;
                    end else begin
                        index_n = index_inc;
                    end
                end
            end
            FETCH: begin
                addr_n = index[L_RAM_SIZE-1:0];
                if (accept) begin
                    a_n     = bus.s_data;
                    cnt_n   = CW'(MAC_LATENCY);
                    state_n = MAC;
                end
            end
            MAC: begin
                // operands stay frozen; the PE result is taken on the terminal count
                if (mac_cnt == '0) begin
                    acc_n   = bus.pe_dout;
                    index_n = index_inc;
                    state_n = (index_inc < len_q) ? FETCH : DONE;
                end else begin
                    cnt_n = mac_cnt - 1'b1;
                end
            end
            DONE: begin
                result_n = acc;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
        sready_n = (state_n == LOAD) || (state_n == FETCH);
        valid_n  = (state_n == MAC);
        busy_n   = (state_n != IDLE);
        done_n   = (state == DONE);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state      <= IDLE;
            len_q      <= '0;
            index      <= '0;
            acc        <= '0;
            a_reg      <= '0;
            mac_cnt    <= '0;
            pe_din_q   <= '0;
            pe_addr_q  <= '0;
            pe_we_q    <= 1'b0;
            pe_valid_q <= 1'b0;
            s_ready_q  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
        end else begin
            state      <= state_n;
            len_q      <= len_n;
            index      <= index_n;
            acc        <= acc_n;
            a_reg      <= a_n;
            mac_cnt    <= cnt_n;
            pe_din_q   <= din_n;
            pe_addr_q  <= addr_n;
            pe_we_q    <= we_n;
            pe_valid_q <= valid_n;
            s_ready_q  <= sready_n;
            busy       <= busy_n;
            done       <= done_n;
            result     <= result_n;
        end
    end
endmodule

// File: tb/tb_pe_feeder.sv
// Self-checking bench for pe_feeder: directed and random dot-product jobs
// against a simple Q24.8 PE model and a vector-level reference.
module tb_pe_feeder;
    localparam int LR = 6;
    localparam int ML = 4;

    logic          aclk = 1'b0;
    logic          areset;
    logic          start;
    logic [LR:0]   len;
    logic          busy;
    logic          done;
    logic [31:0]   result;

    pe_feeder_if #(.L_RAM_SIZE(LR)) bus ();

    pe_feeder #(.L_RAM_SIZE(LR), .MAC_LATENCY(ML)) dut (
        .aclk   (aclk),
        .areset (areset),
        .start  (start),
        .len    (len),
        .bus    (bus),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 aclk = ~aclk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] exp_b    [64];
    logic [31:0] exp_a    [64];
    logic [31:0] exp_part [64];
    int          cov_load [64];
    int          cov_mac  [64];
    int          job_id = 0;
    int          job_mac_base = 0;
    int          mac_starts = 0;
    int          n_sready = 0, n_we = 0, n_valid = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mulq(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return p[39:8];
    endfunction

    // PE model: RAM written on pe_we, MAC result ML cycles after operands settle
    logic [31:0] ram  [64];
    logic [31:0] pipe [ML];
    always @(posedge aclk) begin
        if (bus.pe_we) ram[bus.pe_addr] <= bus.pe_din;
        pipe[0] <= bus.pe_cin + mulq(bus.pe_ain, ram[bus.pe_addr]);
        for (int i = 1; i < ML; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.pe_dout = pipe[ML-1];

    logic        prev_valid = 1'b0;
    logic [31:0] prev_ain, prev_cin;
    logic [LR-1:0] prev_addr;
    int          run = 0;
    always @(negedge aclk) begin
        if (areset) begin
            run        = 0;
            prev_valid = 1'b0;
        end else begin
            if (bus.s_ready)  n_sready++;
            if (bus.pe_we)    n_we++;
            if (bus.pe_valid) n_valid++;
            check("excl", 32'({bus.s_ready & bus.pe_valid, bus.pe_we & bus.pe_valid}), 32'd0);
            if (bus.pe_we) begin
                cov_load[bus.pe_addr] = job_id;
                check("load_din", bus.pe_din, exp_b[bus.pe_addr]);
            end
            if (bus.pe_valid) begin
                cov_mac[bus.pe_addr] = job_id;
                run++;
                if (!prev_valid) begin
                    check("mac_addr", 32'(bus.pe_addr), 32'(mac_starts - job_mac_base));
                    check("mac_ain", bus.pe_ain, exp_a[bus.pe_addr]);
                    if (mac_starts - job_mac_base < 64)
                        check("mac_cin", bus.pe_cin, exp_part[mac_starts - job_mac_base]);
                    mac_starts++;
                end else begin
                    check("mac_hold_ain", bus.pe_ain, prev_ain);
                    check("mac_hold_cin", bus.pe_cin, prev_cin);
                    check("mac_hold_addr", 32'(bus.pe_addr), 32'(prev_addr));
                end
            end else if (prev_valid) begin
                check("mac_len", 32'(run), 32'(ML + 1));
                run = 0;
            end
            prev_valid = bus.pe_valid;
            prev_ain   = bus.pe_ain;
            prev_cin   = bus.pe_cin;
            prev_addr  = bus.pe_addr;
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_s_ready"},  32'(bus.s_ready),  32'd0);
        check({tag, "_pe_we"},    32'(bus.pe_we),    32'd0);
        check({tag, "_pe_valid"}, 32'(bus.pe_valid), 32'd0);
        check({tag, "_busy"},     32'(busy),         32'd0);
        check({tag, "_done"},     32'(done),         32'd0);
        check({tag, "_pe_ain"},   bus.pe_ain,        32'd0);
        check({tag, "_pe_din"},   bus.pe_din,        32'd0);
        check({tag, "_pe_cin"},   bus.pe_cin,        32'd0);
        check({tag, "_pe_addr"},  32'(bus.pe_addr),  32'd0);
        check({tag, "_result"},   result,            32'd0);
    endtask

    // Runs one job from exp_b/exp_a; vmode 0 = valid always, 1 = toggling, 2 = random.
    task automatic run_job(input int n, input int vmode, input int pulse_at_mac, input int abort_at_mac);
        logic [31:0] stream [$];
        logic [31:0] part;
        int k, idx, dones, done_k, sr0, we0, v0;
        bit aborted, pulsed, v;
        job_id++;
        part = 32'd0;
        for (int i = 0; i < n; i++) begin
            exp_part[i] = part;
            part = part + mulq(exp_a[i], exp_b[i]);
        end
        for (int i = 0; i < n; i++) stream.push_back(exp_b[i]);
        for (int i = 0; i < n; i++) stream.push_back(exp_a[i]);
        job_mac_base = mac_starts;
        sr0 = n_sready; we0 = n_we; v0 = n_valid;
        start = 1'b1;
        len   = (LR+1)'(n);
        bus.s_valid = 1'b0;
        @(posedge aclk); #1;
        start = 1'b0;
        len   = (LR+1)'($urandom);
        check("busy_after_start", 32'(busy), 32'd1);
        k = 0; idx = 0; dones = 0; done_k = -1; aborted = 0; pulsed = 0;
        while (k < 3000) begin
            if (done === 1'b1) begin
                dones++;
                if (done_k < 0) begin
                    done_k = k;
                    check("result", result, part);
                    check("busy_at_done", 32'(busy), 32'd0);
                end
            end
            if (done_k >= 0 && k >= done_k + 2) break;
            if (abort_at_mac != 0 && mac_starts - job_mac_base >= abort_at_mac && bus.pe_valid === 1'b1) begin
                #1 areset = 1'b1;
                #1;
                check_zero("abort");
                aborted = 1;
                break;
            end
            start = 1'b0;
            if (pulse_at_mac != 0 && !pulsed && mac_starts - job_mac_base == pulse_at_mac && bus.pe_valid === 1'b1) begin
                start  = 1'b1;
                len    = (LR+1)'(5);
                pulsed = 1;
            end
            case (vmode)
                0:       v = 1'b1;
                1:       v = (k % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            bus.s_valid = v;
            bus.s_data  = (idx < 2*n) ? stream[idx] : (32'hBAD0_0000 | 32'(k));
            if (v && bus.s_ready === 1'b1) idx++;
            @(posedge aclk); #1;
            k++;
        end
        start = 1'b0;
        bus.s_valid = 1'b0;
        if (aborted) begin
            check("abort_no_done", 32'(dones), 32'd0);
        end else begin
            check("done_count", 32'(dones), 32'd1);
            check("words_accepted", 32'(idx), 32'(2*n));
            check("we_cycles", 32'(n_we - we0), 32'(n));
            check("valid_cycles", 32'(n_valid - v0), 32'(n * (ML + 1)));
            if (vmode == 0) check("latency", 32'(done_k), 32'(n + n*(ML+2) + 1));
            if (n == 0) check("len0_quiet", 32'((n_sready - sr0) + (n_we - we0) + (n_valid - v0)), 32'd0);
            if (pulse_at_mac != 0) check("pulse_applied", 32'(pulsed), 32'd1);
        end
    endtask

    initial begin
        int n, c_load, c_mac;
        areset = 1'b0;
        start  = 1'b0;
        len    = '0;
        bus.s_valid = 1'b0;
        bus.s_data  = 32'd0;
        #2 areset = 1'b1;
        #1 check_zero("reset_async");
        repeat (3) @(posedge aclk);
        #1 check_zero("reset");
        areset = 1'b0;

        exp_b[0] = 32'h100; exp_b[1] = 32'h200;
        exp_a[0] = 32'h300; exp_a[1] = 32'h080;
        run_job(2, 0, 0, 0);
        check("basic_const", result, 32'h400);

        run_job(0, 0, 0, 0);
        check("len0_result", result, 32'd0);

        for (int i = 0; i < 64; i++) begin
            exp_b[i] = 32'h100;
            exp_a[i] = 32'h100;
        end
        run_job(64, 1, 0, 0);
        check("len64_const", result, 32'h4000);
        c_load = 0; c_mac = 0;
        for (int i = 0; i < 64; i++) begin
            if (cov_load[i] == job_id) c_load++;
            if (cov_mac[i] == job_id)  c_mac++;
        end
        check("len64_load_cover", 32'(c_load), 32'd64);
        check("len64_mac_cover", 32'(c_mac), 32'd64);

        for (int i = 0; i < 3; i++) begin
            exp_b[i] = $urandom;
            exp_a[i] = $urandom;
        end
        run_job(3, 0, 1, 0);

        for (int i = 0; i < 4; i++) begin
            exp_b[i] = 32'h100 + 32'(i);
            exp_a[i] = 32'h200;
        end
        run_job(4, 0, 0, 2);
        @(posedge aclk); #1;
        check_zero("reset_hold");
        areset = 1'b0;
        exp_b[0] = 32'h200;
        exp_a[0] = 32'h200;
        run_job(1, 0, 0, 0);
        check("after_abort_const", result, 32'h400);

        for (int j = 0; j < 6; j++) begin
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) begin
                exp_b[i] = $urandom;
                exp_a[i] = $urandom;
            end
            run_job(n, (j == 0) ? 0 : 2, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
